// File: rtl/i2c_uart_frame_arbiter_if.sv
// Bus between the I2C controller, the frame arbiter and the UART bridge.
// Defining I2C_ARB_DROPCNT_EN adds the drop_count signal.
interface i2c_uart_frame_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
);
   logic                      i2c_data_rdy;
   logic [1:0]                i2c_valid_instr;
   logic [DATA_W-1:0]         i2c_retrieved_data;
   logic [ADDR_W-1:0]         i2c_instr_address;
   logic [7:0]                i2c_op_info;
   logic [5:0]                failure_signal;
   // A frame transfers on every cycle where out_valid and out_ready are both
   // high. While out_valid is high and out_ready is low, all out_* are held.
   logic                      out_ready;
   logic                      out_valid;
   logic [ADDR_W-1:0]         out_address;
   logic [7:0]                out_mode;
   logic [DATA_W-1:0]         out_data;
   logic                      full_i2cbuffer;
   logic [$clog2(DEPTH):0]    fifo_count;
   logic                      arb_state;
`ifdef I2C_ARB_DROPCNT_EN
   logic [7:0]                drop_count;
`endif

   modport master (
      output i2c_data_rdy, i2c_valid_instr, i2c_retrieved_data,
             i2c_instr_address, i2c_op_info, failure_signal, out_ready,
      input  out_valid, out_address, out_mode, out_data, full_i2cbuffer,
             fifo_count, arb_state
`ifdef I2C_ARB_DROPCNT_EN
      , input drop_count
`endif
   );

   modport slave (
      input  i2c_data_rdy, i2c_valid_instr, i2c_retrieved_data,
             i2c_instr_address, i2c_op_info, failure_signal, out_ready,
      output out_valid, out_address, out_mode, out_data, full_i2cbuffer,
             fifo_count, arb_state
`ifdef I2C_ARB_DROPCNT_EN
      , output drop_count
`endif
   );
endinterface

// File: rtl/i2c_uart_frame_arbiter.sv
// Command FIFO plus one-entry periodic slot feeding a registered UART frame.
// Defining I2C_ARB_DROPCNT_EN adds a saturating count of dropped commands.
module i2c_uart_frame_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 8,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 4
) (
   input logic clk,
   input logic reset,
   i2c_uart_frame_arbiter_if.slave bus
);
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam int SW    = $clog2(STARVE_MAX + 1);
   localparam int REC_W = DATA_W + ADDR_W + 8;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t            state;
   logic [REC_W-1:0]  mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] slot_data;
   logic [5:0]        slot_fail;
   logic              pending;
   logic [SW-1:0]     starve_cnt;
   logic [1:0]        op_enc;
   logic [REC_W-1:0]  head;
   logic              cmd_wr, per_wr, fifo_empty, fifo_full;
   logic              load, sel_per, sel_cmd, pop, push;
   logic              unused_op_hi;

   assign unused_op_hi = ^bus.i2c_op_info[7:4];

   always_comb begin
      op_enc = 2'b00;
      case (bus.i2c_op_info[3:0])
         4'b0001: op_enc = 2'b00;
         4'b0010: op_enc = 2'b01;
         4'b0100: op_enc = 2'b10;
         4'b1000: op_enc = 2'b11;
         default: op_enc = 2'b00;
      endcase
   end

   assign cmd_wr     = bus.i2c_data_rdy && (bus.i2c_valid_instr == 2'b11);
   assign per_wr     = bus.i2c_data_rdy && (bus.i2c_valid_instr == 2'b01);
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(DEPTH));
   assign load       = (state == IDLE) || bus.out_ready;
   assign sel_per    = pending && (fifo_empty || (starve_cnt == SW'(STARVE_MAX)));
   assign sel_cmd    = !sel_per && !fifo_empty;
   assign pop        = load && sel_cmd;
   // A pop frees the slot in the same cycle, so a write while full still lands.
   assign push       = cmd_wr && (!fifo_full || pop);
   assign head       = mem[rd_ptr];

   assign bus.fifo_count     = count;
   assign bus.full_i2cbuffer = fifo_full;
   assign bus.arb_state      = state;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {bus.i2c_retrieved_data, bus.i2c_instr_address,
                         bus.failure_signal, op_enc};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_data  <= '0;
         slot_fail  <= '0;
         pending    <= 1'b0;
         starve_cnt <= '0;
      end else begin
         // A new sample wins over clearing, so it stays pending for the next frame.
         if (per_wr) begin
            slot_data <= bus.i2c_retrieved_data;
            slot_fail <= bus.failure_signal;
            pending   <= 1'b1;
         end else if (load && sel_per) begin
            pending   <= 1'b0;
         end
         if (!pending || (load && sel_per)) begin
            starve_cnt <= '0;
         end else if (pop && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         bus.out_valid   <= 1'b0;
         bus.out_address <= '0;
         bus.out_mode    <= '0;
         bus.out_data    <= '0;
      end else if (load) begin
         if (sel_per) begin
            state           <= HOLD;
            bus.out_valid   <= 1'b1;
            bus.out_address <= '0;
            bus.out_mode    <= {slot_fail, 2'b01};
            bus.out_data    <= slot_data;
         end else if (sel_cmd) begin
            state           <= HOLD;
            bus.out_valid   <= 1'b1;
            bus.out_data    <= head[REC_W-1 -: DATA_W];
            bus.out_address <= head[ADDR_W+7 : 8];
            bus.out_mode    <= head[7:0];
         end else begin
            state           <= IDLE;
            bus.out_valid   <= 1'b0;
            bus.out_address <= '0;
            bus.out_mode    <= '0;
            bus.out_data    <= '0;
         end
      end
   end

`ifdef I2C_ARB_DROPCNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.drop_count <= '0;
      end else if (cmd_wr && !push && (bus.drop_count != 8'hFF)) begin
         bus.drop_count <= bus.drop_count + 8'd1;
      end
   end
`endif
endmodule

// File: tb/tb_i2c_uart_frame_arbiter.sv
// Directed bench for i2c_uart_frame_arbiter: cycle vector table plus
// hand-written multi-cycle sequences checked through an expected-frame queue.
module tb_i2c_uart_frame_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;
   logic [31:0] exp_q[$];

   i2c_uart_frame_arbiter_if #(.DATA_W(16), .ADDR_W(8), .DEPTH(4)) bus ();

   i2c_uart_frame_arbiter #(.DATA_W(16), .ADDR_W(8), .DEPTH(4), .STARVE_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic [1:0]  kind;
      logic [15:0] data;
      logic [7:0]  addr;
      logic [7:0]  op;
      logic [5:0]  fail;
      logic        ordy;
      logic        e_valid;
      logic [15:0] e_data;
      logic [7:0]  e_addr;
      logic [7:0]  e_mode;
      logic [2:0]  e_count;
      logic        e_full;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t vecs[19];

   function automatic vec_t mk(logic rdy, logic [1:0] kind, logic [15:0] d, logic [7:0] a,
                               logic [7:0] op, logic [5:0] f, logic ordy, logic ev,
                               logic [15:0] ed, logic [7:0] ea, logic [7:0] em,
                               logic [2:0] ec, logic ef, logic [7:0] edr);
      vec_t v;
      v.rdy = rdy; v.kind = kind; v.data = d; v.addr = a; v.op = op; v.fail = f;
      v.ordy = ordy; v.e_valid = ev; v.e_data = ed; v.e_addr = ea; v.e_mode = em;
      v.e_count = ec; v.e_full = ef; v.e_drop = edr;
      return v;
   endfunction

   function automatic logic [31:0] frame(logic [7:0] a, logic [7:0] m, logic [15:0] d);
      return {a, m, d};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic drive(logic rdy, logic [1:0] kind, logic [15:0] d, logic [7:0] a,
                        logic [7:0] op, logic [5:0] f, logic ordy);
      bus.i2c_data_rdy       = rdy;
      bus.i2c_valid_instr    = kind;
      bus.i2c_retrieved_data = d;
      bus.i2c_instr_address  = a;
      bus.i2c_op_info        = op;
      bus.failure_signal     = f;
      bus.out_ready          = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(logic [15:0] d, logic [7:0] a, logic ordy);
      drive(1'b1, 2'b11, d, a, 8'h01, 6'h00, ordy);
      tick();
   endtask

   task automatic idle(logic ordy, int n);
      for (int k = 0; k < n; k++) begin
         drive(1'b0, 2'b00, 16'h0, 8'h0, 8'h0, 6'h0, ordy);
         tick();
      end
   endtask

   // Frame monitor: inputs change just after posedge, so negedge sees a settled handshake.
   always @(negedge clk) begin
      if (mon_en && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got %h, want no frame",
                     frame(bus.out_address, bus.out_mode, bus.out_data));
         end else begin
            check("frame_order", frame(bus.out_address, bus.out_mode, bus.out_data),
                  exp_q.pop_front());
         end
      end
   end

   initial begin
`ifdef I2C_ARB_DROPCNT_EN
      logic [7:0] drop_before;
`endif
      vecs[0]  = mk(1, 2'b11, 16'hABCD, 8'h05, 8'h02, 6'h00, 1, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0);
      vecs[1]  = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 1, 16'hABCD, 8'h05, 8'h01, 0, 0, 0);
      vecs[2]  = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0);
      vecs[3]  = mk(1, 2'b11, 16'h1111, 8'h11, 8'h01, 6'h01, 0, 0, 16'h0000, 8'h00, 8'h00, 1, 0, 0);
      vecs[4]  = mk(1, 2'b11, 16'h2222, 8'h22, 8'h04, 6'h02, 0, 1, 16'h1111, 8'h11, 8'h04, 1, 0, 0);
      vecs[5]  = mk(1, 2'b11, 16'h3333, 8'h33, 8'h08, 6'h03, 0, 1, 16'h1111, 8'h11, 8'h04, 2, 0, 0);
      vecs[6]  = mk(1, 2'b11, 16'h4444, 8'h44, 8'h03, 6'h04, 0, 1, 16'h1111, 8'h11, 8'h04, 3, 0, 0);
      vecs[7]  = mk(1, 2'b11, 16'h5555, 8'h55, 8'h01, 6'h05, 0, 1, 16'h1111, 8'h11, 8'h04, 4, 1, 0);
      vecs[8]  = mk(1, 2'b11, 16'h6666, 8'h66, 8'h02, 6'h06, 0, 1, 16'h1111, 8'h11, 8'h04, 4, 1, 1);
      vecs[9]  = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 1, 16'h2222, 8'h22, 8'h0A, 3, 0, 1);
      vecs[10] = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 1, 16'h3333, 8'h33, 8'h0F, 2, 0, 1);
      vecs[11] = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 1, 16'h4444, 8'h44, 8'h10, 1, 0, 1);
      vecs[12] = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 1, 16'h5555, 8'h55, 8'h14, 0, 0, 1);
      vecs[13] = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1);
      vecs[14] = mk(1, 2'b01, 16'h0ABC, 8'h99, 8'hF1, 6'h3F, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1);
      vecs[15] = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 1, 16'h0ABC, 8'h00, 8'hFD, 0, 0, 1);
      vecs[16] = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1);
      vecs[17] = mk(1, 2'b10, 16'hDEAD, 8'h12, 8'h01, 6'h00, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1);
      vecs[18] = mk(0, 2'b00, 16'h0000, 8'h00, 8'h00, 6'h00, 1, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 1);

      drive(1'b0, 2'b00, 16'h0, 8'h0, 8'h0, 6'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", bus.out_valid, 0);
      check("rst_count", bus.fifo_count, 0);
      check("rst_full", bus.full_i2cbuffer, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].rdy, vecs[i].kind, vecs[i].data, vecs[i].addr, vecs[i].op,
               vecs[i].fail, vecs[i].ordy);
         tick();
         check($sformatf("v%0d_valid", i), bus.out_valid, vecs[i].e_valid);
         check($sformatf("v%0d_count", i), bus.fifo_count, vecs[i].e_count);
         check($sformatf("v%0d_full", i), bus.full_i2cbuffer, vecs[i].e_full);
         if (vecs[i].e_valid) begin
            check($sformatf("v%0d_frame", i), frame(bus.out_address, bus.out_mode, bus.out_data),
                  frame(vecs[i].e_addr, vecs[i].e_mode, vecs[i].e_data));
         end
`ifdef I2C_ARB_DROPCNT_EN
         check($sformatf("v%0d_drop", i), bus.drop_count, vecs[i].e_drop);
`endif
      end

      // Periodic overwrite while a command frame is held.
      mon_en = 1'b1;
      exp_q.push_back(frame(8'h77, 8'h00, 16'h7777));
      exp_q.push_back(frame(8'h00, 8'hA9, 16'h0200));
      push_cmd(16'h7777, 8'h77, 1'b0);
      drive(1'b1, 2'b01, 16'h0100, 8'h00, 8'h00, 6'h00, 1'b0);
      tick();
      drive(1'b1, 2'b01, 16'h0200, 8'h00, 8'h00, 6'h2A, 1'b0);
      tick();
      idle(1'b1, 4);
      check("ovw_q_empty", exp_q.size(), 0);
      check("ovw_idle", bus.out_valid, 0);

      // Starvation guard with a full FIFO kept topped up.
      for (int k = 1; k <= 5; k++) begin
         exp_q.push_back(frame(8'hB0 + 8'(k), 8'h00, 16'hB000 + 16'(k)));
      end
      exp_q.push_back(frame(8'h00, 8'h01, 16'h0BEE));
      for (int k = 6; k <= 8; k++) begin
         exp_q.push_back(frame(8'hB0 + 8'(k), 8'h00, 16'hB000 + 16'(k)));
      end
      for (int k = 1; k <= 5; k++) begin
         push_cmd(16'hB000 + 16'(k), 8'hB0 + 8'(k), 1'b0);
      end
      check("starve_full", bus.full_i2cbuffer, 1);
      drive(1'b1, 2'b01, 16'h0BEE, 8'h00, 8'h00, 6'h00, 1'b0);
      tick();
`ifdef I2C_ARB_DROPCNT_EN
      drop_before = bus.drop_count;
`endif
      push_cmd(16'hB006, 8'hB6, 1'b1);
      check("pushpop_count", bus.fifo_count, 4);
      check("pushpop_full", bus.full_i2cbuffer, 1);
`ifdef I2C_ARB_DROPCNT_EN
      check("pushpop_drop", bus.drop_count, drop_before);
`endif
      push_cmd(16'hB007, 8'hB7, 1'b1);
      push_cmd(16'hB008, 8'hB8, 1'b1);
      check("pushpop_count2", bus.fifo_count, 4);
      idle(1'b1, 7);
      check("starve_q_empty", exp_q.size(), 0);
      check("starve_idle", bus.out_valid, 0);

      // Reset while a frame is held, FIFO has 3 entries and a sample waits.
      for (int k = 1; k <= 4; k++) begin
         push_cmd(16'hD000 + 16'(k), 8'hD0 + 8'(k), 1'b0);
      end
      drive(1'b1, 2'b01, 16'h0D0D, 8'h00, 8'h00, 6'h00, 1'b0);
      tick();
      check("pre_rst_valid", bus.out_valid, 1);
      check("pre_rst_count", bus.fifo_count, 3);
      reset = 1'b1;
      #1;
      check("mid_rst_valid", bus.out_valid, 0);
      check("mid_rst_count", bus.fifo_count, 0);
      check("mid_rst_full", bus.full_i2cbuffer, 0);
`ifdef I2C_ARB_DROPCNT_EN
      check("mid_rst_drop", bus.drop_count, 0);
`endif
      idle(1'b0, 2);
      reset = 1'b0;
      idle(1'b1, 6);
      check("post_rst_valid", bus.out_valid, 0);
      check("post_rst_count", bus.fifo_count, 0);
      mon_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
